aes_key_schedule_seq: RTL
=========================

Name: aes_key_schedule_seq

Overview:
Sequential, parametrised AES key schedule. Covers AES-128, AES-192 and AES-256 through the KEY_BITS parameter. Expands the cipher key one 32-bit word per cycle and emits 128-bit round keys 0..NR in order over a valid/ready stream. It feeds the sequential AES round datapath, which consumes one round key per round.

Parameters:
- KEY_BITS, 128, cipher key width. Legal values: 128, 192, 256. Any other value is an elaboration error.
- NK (localparam), KEY_BITS/32, number of key words (4, 6 or 8).
- NR (localparam), NK+6, number of rounds (10, 12 or 14).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin expansion of key. Sampled only when busy=0.
- key  in  KEY_BITS  cipher key. Word j is key[32j+31:32j]; byte 0 of each word is bits [7:0].
- busy  out  1  expansion in progress.
- rk_valid  out  1  rk and rk_index hold a valid round key.
- rk_ready  in  1  consumer accepts the round key when rk_valid && rk_ready.
- rk  out  128  round key r = words 4r..4r+3, with word 4r in bits [31:0].
- rk_index  out  4  round number r, 0..NR.
- done  out  1  one-cycle pulse on acceptance of round key NR.

Behaviour:
- Reset: busy=0, rk_valid=0, done=0, rk=0, rk_index=0; all counters and the word window are cleared.
- Reset has priority over every other event. Asserting it mid-expansion aborts the expansion with no done pulse.
- States:
  - IDLE: waits for start.
  - GEN: produces words.
  - DRAIN: all words produced; waits for acceptance of the final round key.
- IDLE -> GEN at the edge where start=1. At that edge key is latched into an NK-word window, word index i=0 and busy=1.
- start while busy=1 is ignored. The key input is not sampled after the start edge.
- GEN produces word w[i] at each enabled edge, then i increments:
  - For i<NK: w[i] = latched key word i.
  - For i>=NK:
    - temp = w[i-1].
    - If i mod NK == 0: temp = SubWord(RotWord(temp)), and byte 0 of temp is XORed with Rcon[i/NK-1]. RotWord(x) = {x[7:0], x[31:8]}. Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
    - Else if NK==8 and i mod 8 == 4: temp = SubWord(temp).
    - w[i] = w[i-NK] ^ temp.
  - SubWord applies the AES S-box to each byte and is combinational.
  - The window is a shift register holding w[i-NK]..w[i-1].
- Assembly:
  - Words collect in a 3-word staging register.
  - The edge that produces word 4r+3 loads rk = {w[4r+3], staged three}, sets rk_index=r and sets rk_valid=1.
  - That edge is enabled only when rk_valid==0 || rk_ready==1. Otherwise GEN holds with no word produced and no state change.
  - Words 4r..4r+2 are never stalled.
- Acceptance (rk_valid && rk_ready) clears rk_valid at that edge, unless the same edge loads the next round key. In that case rk_valid stays 1 and rk/rk_index update.
- Latency and throughput:
  - With start at edge T and no backpressure, round key 0 is valid from edge T+4.
  - Round key r is valid from edge T+4(r+1).
  - Throughput is one round key per 4 cycles.
  - Total words produced = 4(NR+1): 44, 52 or 60. i is 6 bits and never wraps.
- After word 4NR+3 is produced: GEN -> DRAIN.
- On acceptance of rk_index==NR: done=1 for one cycle, busy=0, DRAIN -> IDLE.
- A start in the same cycle as the final acceptance is ignored. busy is still 1 in that cycle.
- rk and rk_index hold their last values while idle. rk_valid=0 while idle.

Test Plan:
- AES-128 (FIPS-197 A.1), key bytes 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1:
  - rk_index 1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - rk_index 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - Round key 0 valid 4 cycles after start; done 44 cycles after start.
- AES-192 (A.2), key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - rk_index 12 = e98ba06f 448c773c 8ecc7204 01002202.
  - Exactly 13 handshakes, then done.
- AES-256 (A.3), key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - rk_index 1 = 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - rk_index 14 = fe4890d1 e6188d0b 046df344 706c631e.
- Backpressure: hold rk_ready=0 for 20 cycles after round key 0 appears, then randomise rk_ready.
  - rk and rk_index remain stable while stalled.
  - No round key is skipped or duplicated.
  - Final values match the same run without backpressure.
- Reset mid-run: assert rst during round 5 of AES-128.
  - Next cycle: busy=0, rk_valid=0, no done pulse.
  - A new start then produces correct keys from round 0.
- start pulsed while busy, and in the cycle of the final handshake: both ignored, with no corruption of the sequence.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one expanded word per cycle,
// 128-bit round keys 0..NR streamed out over valid/ready.
module aes_key_schedule_seq #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KEY_BITS-1:0] key,
   output logic                busy,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [127:0]        rk,
   output logic [3:0]          rk_index,
   output logic                done
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam logic [5:0] LAST = 6'(4 * NR + 3);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("KEY_BITS must be 128, 192 or 256");
   end

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   function automatic logic [31:0] subword(input logic [31:0] x);
      return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

   state_t             state, state_n;
   logic [NK-1:0][31:0] win;
   logic [2:0][31:0]   stg;
   logic [5:0]         i;
   logic [2:0]         j;
   logic [7:0]         rcon;
   logic               ext, en, load, acc;
   logic [31:0]        prev, temp, wnew;

   // win[0] is w[i-NK], win[NK-1] is w[i-1]
   assign prev = win[NK-1];
   assign ext  = (i >= 6'(NK));
   assign wnew = ext ? (win[0] ^ temp) : win[0];
   assign acc  = rk_valid && rk_ready;
   assign en   = (state == GEN) && ((i[1:0] != 2'd3) || !rk_valid || rk_ready);
   assign load = en && (i[1:0] == 2'd3);
   assign busy = (state != IDLE);
   assign done = !rst && (state == DRAIN) && acc;

   always_comb begin
      temp = prev;
      if (j == 3'd0)
         temp = subword({prev[7:0], prev[31:8]}) ^ {24'h0, rcon};
      else if (NK == 8 && j == 3'd4)
         temp = subword(prev);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = GEN;
         GEN:     if (en && i == LAST) state_n = DRAIN;
         DRAIN:   if (acc) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win      <= '0;
         stg      <= '0;
         i        <= '0;
         j        <= '0;
         rcon     <= 8'h01;
         rk       <= '0;
         rk_index <= '0;
         rk_valid <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            win  <= key;
            i    <= '0;
            j    <= '0;
            rcon <= 8'h01;
         end
         // key words rotate through unchanged until the window holds w[0..NK-1]
         if (en) begin
            win <= {wnew, win[NK-1:1]};
            i   <= i + 6'd1;
            j   <= (j == 3'(NK - 1)) ? 3'd0 : j + 3'd1;
            if (ext && j == 3'd0) rcon <= xtime(rcon);
            if (i[1:0] == 2'd0)      stg[0] <= wnew;
            else if (i[1:0] == 2'd1) stg[1] <= wnew;
            else if (i[1:0] == 2'd2) stg[2] <= wnew;
         end
         if (load) begin
            rk       <= {wnew, stg};
            rk_index <= i[5:2];
            rk_valid <= 1'b1;
         end else if (acc) begin
            rk_valid <= 1'b0;
         end
      end
   end

endmodule
